irrigacao_escalonador: RTL and testbench
========================================

IRRIGACAO_ESCALONADOR -- requirements
Module: irrigacao_escalonador

Interface
REQ-001 The block SHALL have parameter MIN_ON, default 4, minimum valve-open time in clock cycles (legal range >=1).
REQ-002 The block SHALL have parameter MAX_ON, default 16, maximum valve-open time in cycles per grant (legal range >=MIN_ON, <=255).
REQ-003 The block SHALL have parameter PAUSA, default 2, pump spin-down time in cycles between grants (legal range >=1, <=255).
REQ-004 The block SHALL use one clock and an asynchronous active-high reset: clk input 1 bit, rising-edge system clock.
REQ-005 reset  input  1  asynchronous active-high reset.
REQ-006 U  input  2  asynchronous humidity sensors; bit i = 1 means area i has low humidity.
REQ-007 enable  input  1  synchronous master enable for irrigation.
REQ-008 Saida  output  2  synchronized humidity status, encoded 00 both adequate, 01 area 0 low, 10 area 1 low, 11 both low.
REQ-009 Valvula  output  2  valve drive for the single shared pump; bit i opens area i; at most one bit high.
REQ-010 ocupado  output  1  high while the controller is not in IDLE.
REQ-011 alarme  output  1  one-cycle pulse when a grant ends by MAX_ON timeout.

Function
REQ-012 U SHALL pass through a 2-flop synchronizer; Saida SHALL equal the second stage, i.e. U delayed 2 cycles.
REQ-013 demand[i] SHALL be Saida[i] & enable.
REQ-014 The FSM SHALL have states IDLE, REGA and PAUSA; all outputs except Saida SHALL be registered from state.
REQ-015 In IDLE with demand == 00, the FSM SHALL stay in IDLE.
REQ-016 In IDLE with exactly one demand bit set, the FSM SHALL grant that area and enter REGA on the next edge.
REQ-017 In IDLE with demand == 11, the FSM SHALL grant the area that is not equal to the round-robin pointer ult (last area served).
REQ-018 On entry to REGA, the 8-bit counter cnt SHALL clear to 0; it SHALL increment once per REGA cycle; Valvula SHALL be one-hot on the granted area for every REGA cycle.
REQ-019 REGA SHALL exit to PAUSA when cnt >= MIN_ON-1 and demand[granted] == 0 (normal end).
REQ-020 REGA SHALL exit to PAUSA when cnt == MAX_ON-1 (timeout). alarme SHALL pulse high for the first PAUSA cycle.
REQ-021 Timeout SHALL take priority when both exit conditions hold; alarme still pulses.
REQ-022 enable falling during REGA SHALL force exit to PAUSA on the next edge, overriding MIN_ON. No alarme SHALL be raised.
REQ-023 The valve SHALL therefore be open for at least MIN_ON cycles and at most MAX_ON cycles, except on enable abort.
REQ-024 On every REGA exit, ult SHALL take the granted area.
REQ-025 In PAUSA, Valvula SHALL be 00; cnt SHALL clear on entry and count PAUSA cycles; the FSM SHALL return to IDLE after exactly PAUSA cycles, regardless of demand or enable.
REQ-026 Valvula SHALL never be 11, and SHALL never be nonzero outside REGA.
REQ-027 Changes on U or on the other area's demand during REGA SHALL NOT preempt the current grant.
REQ-028 Latency: a U edge SHALL reach Saida after 2 cycles; Valvula SHALL rise at earliest 3 cycles after the U edge, when starting from IDLE.

Reset
REQ-029 On reset assertion, regardless of clock, the block SHALL go to state IDLE and set Valvula=00, ocupado=0, alarme=0, Saida=00, synchronizer flops=00, cnt=0, ult=1 (area 0 wins the first tie).
REQ-030 Reset asserted mid-REGA SHALL close the valve immediately, with no PAUSA.

Verification
REQ-031 U=01, enable=1, U drops to 00 after 2 cycles of valve-open -> Valvula=01 from cycle 3; valve held exactly 4 cycles (MIN_ON); then 2 PAUSA cycles with Valvula=00; ocupado=1 throughout; then IDLE.
REQ-032 U=11 held constant after reset -> grants alternate 01, 10, 01; each grant lasts 16 cycles; alarme pulses after each grant; PAUSA gap of 2 cycles between grants.
REQ-033 U=10, then U=11 during REGA -> area 1 is not preempted; after area 1's grant ends and PAUSA completes, area 0 is granted.
REQ-034 Area 0 in REGA at cnt=1, enable cleared -> Valvula=00 on the next edge, state PAUSA, alarme=0.
REQ-035 Area 1 in REGA, reset pulsed asynchronously between clock edges -> Valvula=00 and Saida=00 immediately; after release with U=00, the block stays in IDLE.
REQ-036 Random U/enable run with assertions -> Valvula never 11; Valvula nonzero only in REGA; open time in [MIN_ON, MAX_ON] unless aborted by enable or reset.

Source files
------------

// File: rtl/irrigacao_escalonador_if.sv
// Signal bundle for the irrigation scheduler.
//   U       : raw (asynchronous) low-humidity flags, bit i = area i dry
//   enable  : synchronous master enable for irrigation
//   Saida   : synchronized humidity status (U delayed two cycles)
//   Valvula : one-hot valve drive for the shared pump, 00 when closed
//   ocupado : controller busy (not idle)
//   alarme  : one-cycle pulse when a grant ended by timeout
// master modport drives U/enable (environment); slave modport is the scheduler.
interface irrigacao_escalonador_if;
  logic [1:0] U;
  logic       enable;
  logic [1:0] Saida;
  logic [1:0] Valvula;
  logic       ocupado;
  logic       alarme;

  modport master (
    output U, enable,
    input  Saida, Valvula, ocupado, alarme
  );

  modport slave (
    input  U, enable,
    output Saida, Valvula, ocupado, alarme
  );
endinterface

// File: rtl/irrigacao_escalonador.sv
// Two-area irrigation scheduler sharing a single pump.
// Synchronizes the humidity sensors, grants the pump to one dry area at a
// time (round-robin on ties), keeps the valve open between MIN_ON and MAX_ON
// cycles, then lets the pump spin down for PAUSA cycles before the next grant.
// Ports:
//   clk   : rising-edge system clock
//   reset : asynchronous active-high reset
//   bus   : slave side of irrigacao_escalonador_if (U, enable in;
//           Saida, Valvula, ocupado, alarme out)
module irrigacao_escalonador #(
  parameter int MIN_ON = 4,
  parameter int MAX_ON = 16,
  parameter int PAUSA  = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  irrigacao_escalonador_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REGA  = 2'd1,
    S_PAUSA = 2'd2
  } state_t;

  localparam logic [7:0] MIN_LAST   = 8'(MIN_ON - 1);
  localparam logic [7:0] MAX_LAST   = 8'(MAX_ON - 1);
  localparam logic [7:0] PAUSA_LAST = 8'(PAUSA - 1);

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       ult, ult_nxt;
  logic       grant, grant_nxt;
  logic [1:0] sync1, saida_q;
  logic [1:0] valvula_q, valvula_nxt;
  logic       ocupado_q, ocupado_nxt;
  logic       alarme_q, alarme_nxt;
  logic [1:0] demand;

  assign demand      = saida_q & {2{bus.enable}};
  assign bus.Saida   = saida_q;
  assign bus.Valvula = valvula_q;
  assign bus.ocupado = ocupado_q;
  assign bus.alarme  = alarme_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      ult       <= 1'b1;
      grant     <= 1'b0;
      sync1     <= '0;
      saida_q   <= '0;
      valvula_q <= '0;
      ocupado_q <= 1'b0;
      alarme_q  <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      ult       <= ult_nxt;
      grant     <= grant_nxt;
      sync1     <= bus.U;
      saida_q   <= sync1;
      valvula_q <= valvula_nxt;
      ocupado_q <= ocupado_nxt;
      alarme_q  <= alarme_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt + 8'd1;
    ult_nxt    = ult;
    grant_nxt  = grant;
    alarme_nxt = 1'b0;

    case (state)
      S_IDLE: begin
        cnt_nxt = '0;
        if (demand != 2'b00) begin
          state_nxt = S_REGA;
          // On a tie the area that was not served last wins.
          grant_nxt = (demand == 2'b11) ? ~ult : demand[1];
        end
      end
      S_REGA: begin
        // Abort on enable loss is checked first so it never raises alarme,
        // even if the timeout would have fired on the same edge.
        if (!bus.enable) begin
          state_nxt = S_PAUSA;
          cnt_nxt   = '0;
          ult_nxt   = grant;
        end else if (cnt == MAX_LAST) begin
          state_nxt  = S_PAUSA;
          cnt_nxt    = '0;
          ult_nxt    = grant;
          alarme_nxt = 1'b1;
        end else if (cnt >= MIN_LAST && !demand[grant]) begin
          state_nxt = S_PAUSA;
          cnt_nxt   = '0;
          ult_nxt   = grant;
        end
      end
      S_PAUSA: begin
        if (cnt == PAUSA_LAST) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase

    // Outputs are registered from the next state so they line up with state.
    valvula_nxt = (state_nxt == S_REGA) ? (grant_nxt ? 2'b10 : 2'b01) : 2'b00;
    ocupado_nxt = (state_nxt != S_IDLE);
  end

endmodule

// File: tb/tb_irrigacao_escalonador.sv
// Self-checking bench for irrigacao_escalonador: a table of per-cycle vectors
// for the basic single-area grant, hand sequences for the multi-cycle corner
// cases, and a randomized run checked against a behavioural model.
module tb_irrigacao_escalonador;
  localparam int MIN_ON = 4;
  localparam int MAX_ON = 16;
  localparam int PAUSA  = 2;

  logic clk = 1'b0;
  logic reset;
  irrigacao_escalonador_if ifc ();

  irrigacao_escalonador #(.MIN_ON(MIN_ON), .MAX_ON(MAX_ON), .PAUSA(PAUSA)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Behavioural model: pipeline of sensor samples, the open area (-1 = none),
  // how many cycles it has been open, remaining spin-down cycles.
  int m_s1, m_sat, m_area, m_open, m_pause, m_last, m_alarm;

  // Grant tracker
  int grants[$];
  int lens[$];
  int n_alarm;
  int prev_v;

  typedef struct {
    logic [1:0] u;
    logic       en;
    logic [1:0] valv;
    logic       oc;
    logic       al;
    logic [1:0] saida;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1 = 0; m_sat = 0; m_area = -1; m_open = 0; m_pause = 0; m_last = 1; m_alarm = 0;
  endtask

  task automatic end_grant(input int al);
    m_last  = m_area;
    m_area  = -1;
    m_pause = PAUSA;
    m_alarm = al;
  endtask

  task automatic model_step(input int u, input int en);
    int dem;
    dem = m_sat & (en != 0 ? 3 : 0);
    m_alarm = 0;
    if (m_area >= 0) begin
      if (en == 0) end_grant(0);
      else if (m_open == MAX_ON) end_grant(1);
      else if (m_open >= MIN_ON && ((dem >> m_area) & 1) == 0) end_grant(0);
      else m_open++;
    end else if (m_pause > 0) begin
      m_pause--;
    end else if (dem != 0) begin
      m_area = (dem == 3) ? 1 - m_last : ((dem == 2) ? 1 : 0);
      m_open = 1;
    end
    m_sat = m_s1;
    m_s1  = u;
  endtask

  task automatic track_clear();
    grants.delete(); lens.delete(); n_alarm = 0; prev_v = 0;
  endtask

  // One clock: drive after negedge, let the edge happen, compare #1 later.
  task automatic tick(input logic [1:0] u, input logic en);
    int v;
    ifc.U = u;
    ifc.enable = en;
    @(posedge clk);
    model_step(int'(u), int'(en));
    #1;
    chk("Saida",   int'(ifc.Saida),   m_sat);
    chk("Valvula", int'(ifc.Valvula), (m_area < 0) ? 0 : ((m_area == 1) ? 2 : 1));
    chk("ocupado", int'(ifc.ocupado), (m_area >= 0 || m_pause > 0) ? 1 : 0);
    chk("alarme",  int'(ifc.alarme),  m_alarm);
    v = int'(ifc.Valvula);
    if (v != 0 && prev_v == 0) begin
      grants.push_back(v);
      lens.push_back(0);
    end
    if (v != 0) lens[lens.size()-1]++;
    if (ifc.alarme) n_alarm++;
    prev_v = v;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ifc.U = 2'b00;
    ifc.enable = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    track_clear();
  endtask

  // Bounded wait for a given valve value; expiry counts as a failure.
  task automatic wait_valv(input logic [1:0] target, input logic [1:0] u, input logic en);
    bit seen;
    seen = 0;
    for (int i = 0; i < 12 && !seen; i++) begin
      tick(u, en);
      if (ifc.Valvula == target) seen = 1;
    end
    chk("wait_valv_reached", int'(seen), 1);
  endtask

  vec_t tbl[10];

  initial begin
    tbl[0] = '{2'b01, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00};
    tbl[1] = '{2'b01, 1'b1, 2'b00, 1'b0, 1'b0, 2'b01};
    tbl[2] = '{2'b01, 1'b1, 2'b01, 1'b1, 1'b0, 2'b01};
    tbl[3] = '{2'b01, 1'b1, 2'b01, 1'b1, 1'b0, 2'b01};
    tbl[4] = '{2'b00, 1'b1, 2'b01, 1'b1, 1'b0, 2'b01};
    tbl[5] = '{2'b00, 1'b1, 2'b01, 1'b1, 1'b0, 2'b00};
    tbl[6] = '{2'b00, 1'b1, 2'b00, 1'b1, 1'b0, 2'b00};
    tbl[7] = '{2'b00, 1'b1, 2'b00, 1'b1, 1'b0, 2'b00};
    tbl[8] = '{2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00};
    tbl[9] = '{2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00};

    ifc.U = 2'b00;
    ifc.enable = 1'b0;
    reset = 1'b1;
    model_reset();
    #1;
    chk("rst_Valvula", int'(ifc.Valvula), 0);
    chk("rst_Saida",   int'(ifc.Saida),   0);
    chk("rst_ocupado", int'(ifc.ocupado), 0);
    chk("rst_alarme",  int'(ifc.alarme),  0);
    @(negedge clk);
    reset = 1'b0;
    track_clear();

    // Single area, demand withdrawn early: valve held exactly MIN_ON cycles.
    for (int i = 0; i < 10; i++) begin
      tick(tbl[i].u, tbl[i].en);
      chk("tbl_Valvula", int'(ifc.Valvula), int'(tbl[i].valv));
      chk("tbl_ocupado", int'(ifc.ocupado), int'(tbl[i].oc));
      chk("tbl_alarme",  int'(ifc.alarme),  int'(tbl[i].al));
      chk("tbl_Saida",   int'(ifc.Saida),   int'(tbl[i].saida));
    end
    chk("tbl_len", (lens.size() > 0) ? lens[0] : -1, MIN_ON);

    // Both areas dry forever: alternating timeouts 01,10,01.
    do_reset();
    for (int i = 0; i < 65; i++) tick(2'b11, 1'b1);
    chk("rr_ngrants", (grants.size() >= 3) ? 1 : 0, 1);
    if (grants.size() >= 3) begin
      chk("rr_g0", grants[0], 1);
      chk("rr_g1", grants[1], 2);
      chk("rr_g2", grants[2], 1);
      chk("rr_l0", lens[0], MAX_ON);
      chk("rr_l1", lens[1], MAX_ON);
      chk("rr_l2", lens[2], MAX_ON);
    end
    chk("rr_alarms", n_alarm, 3);

    // Area 1 granted, then area 0 also dry: no preemption, area 0 next.
    do_reset();
    wait_valv(2'b10, 2'b10, 1'b1);
    for (int i = 0; i < 45; i++) tick(2'b11, 1'b1);
    chk("np_ngrants", (grants.size() >= 2) ? 1 : 0, 1);
    if (grants.size() >= 2) begin
      chk("np_g0", grants[0], 2);
      chk("np_l0", lens[0], MAX_ON);
      chk("np_g1", grants[1], 1);
    end

    // Enable dropped at cnt=1: valve closes on the next edge without alarme.
    do_reset();
    wait_valv(2'b01, 2'b01, 1'b1);
    tick(2'b01, 1'b1);
    tick(2'b01, 1'b0);
    chk("ab_Valvula", int'(ifc.Valvula), 0);
    chk("ab_ocupado", int'(ifc.ocupado), 1);
    chk("ab_alarme",  int'(ifc.alarme),  0);
    for (int i = 0; i < 4; i++) tick(2'b00, 1'b1);
    chk("ab_idle", int'(ifc.ocupado), 0);

    // Asynchronous reset in the middle of an area-1 grant.
    do_reset();
    wait_valv(2'b10, 2'b10, 1'b1);
    tick(2'b10, 1'b1);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("ar_Valvula", int'(ifc.Valvula), 0);
    chk("ar_Saida",   int'(ifc.Saida),   0);
    chk("ar_ocupado", int'(ifc.ocupado), 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) tick(2'b00, 1'b1);
    chk("ar_stay_idle", int'(ifc.ocupado), 0);

    // Randomized run against the model.
    do_reset();
    begin
      logic [1:0] u;
      logic en;
      u = 2'b00;
      en = 1'b1;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 7) == 0) u = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 15) == 0) en = ~en;
        else if ($urandom_range(0, 3) == 0) en = 1'b1;
        tick(u, en);
        if (ifc.Valvula == 2'b11) chk("valv_onehot", int'(ifc.Valvula), 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
